// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory-bus arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_e;

  localparam int ARB_XLEN         = 32;
  localparam int ARB_MAX_D_STREAK = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = ARB_XLEN
);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic [31:0]     i_rdata;
  logic            i_done;
  logic            d_load;
  logic            d_store;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_ack;
  logic [XLEN-1:0] m_rdata;
  logic            stall;

  modport master (
    input  i_req, i_addr, d_load, d_store, d_addr, d_wdata, m_ack, m_rdata,
    output i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata, stall
  );

  modport slave (
    output i_req, i_addr, d_load, d_store, d_addr, d_wdata, m_ack, m_rdata,
    input  i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store,
// data first, with a bounded data streak so a waiting fetch is eventually served.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = ARB_XLEN,
  parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int            SW         = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam bit            FAIR       = (MAX_D_STREAK > 0);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic            i_pend, d_pend, grant_i, grant_d;

  // A requester still holding its request during its own done cycle is not re-served.
  assign i_pend = bus.i_req & ~i_done_q;
  assign d_pend = (bus.d_load | bus.d_store) & ~d_done_q;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (d_pend && (!i_pend || !FAIR || streak_q < STREAK_MAX)) grant_d = 1'b1;
        else if (i_pend)                                            grant_i = 1'b1;
        if (grant_d) begin
          state_d   = ARB_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_store;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
        end else if (grant_i) begin
          state_d  = ARB_I;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = bus.i_addr;
        end
      end
      ARB_I, ARB_D: begin
        if (bus.m_ack) begin
          state_d = ARB_IDLE;
          m_req_d = 1'b0;
          if (state_q == ARB_I) begin
            i_rdata_d = bus.m_rdata[31:0];
            i_done_d  = 1'b1;
          end else begin
            d_rdata_d = bus.m_rdata;
            d_done_d  = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Streak counts only data grants that overtook a waiting fetch.
    if (!bus.i_req || grant_i)                           streak_d = '0;
    else if (grant_d && i_pend && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.stall   = i_pend | d_pend;
endmodule
